i2c_master: RTL and testbench
=============================

# i2c_master

CSR-controlled I2C bus initiator for the board-management CPLD, the counterpart to the CPLD's existing I2C responder. It sits on the internal CSR bus at two consecutive addresses. Software drives byte-level commands: START, WRITE, READ and STOP. The block generates open-drain SCL/SDA waveforms, honours target clock stretching, and flags completion through a status bit and an optional interrupt OR-ed into the CPLD interrupt line.

## Interface
- BASE_ADDR, 5'h1c, CSR address of CMD/STATUS; DATA is at BASE_ADDR+1.
- CLK_DIV, 8'd12, clk cycles per quarter SCL period (about 100 kHz at the internal oscillator rate). Legal range 2..255.

- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- csr_a  input  5  CSR address.
- csr_di  input  8  CSR write data.
- csr_we  input  1  CSR write strobe, one cycle.
- csr_do  output  8  CSR read data; 8'h00 unless csr_a hits this block's addresses (OR-bus).
- scl_in  input  1  SCL pad level.
- sda_in  input  1  SDA pad level.
- scl_oe  output  1  1 = drive SCL low, 0 = release.
- sda_oe  output  1  1 = drive SDA low, 0 = release.
- irq  output  1  level interrupt, DONE & IRQ_EN.

## Operation
- scl_in and sda_in each pass through a 2-FF synchronizer before any use.
- CMD write at BASE_ADDR:
  - bit0 START, bit1 STOP, bit2 WR, bit3 RD, bit4 IRQ_EN (always loaded), bit5 write 1 to clear DONE.
  - bit6 NACK: for RD, send NACK instead of ACK.
- CMD writes while BUSY are ignored entirely.
- Command bits [3:0] non-zero starts a sequence and sets BUSY. Sequence order: START, then byte (WR if set, else RD if set), then STOP. Absent steps are skipped.
- Setting DONE at sequence end clears DONE only via bit5. A new sequence clears DONE and NACKED at launch.
- STATUS read at BASE_ADDR: bit7 BUSY, bit6 NACKED, bit5 DONE, bit4 IRQ_EN, bits3:0 zero.
- DATA at BASE_ADDR+1:
  - Write loads the TX shift byte; ignored while BUSY.
  - Read returns the last received byte.
- FSM states: IDLE, START, DATA, ACK, STOP, FINISH. Each bit takes 4 phases P0..P3, each CLK_DIV cycles.
  - START: P0 release SDA, hold SCL as-is. P1 release SCL, wait for SCL high. P2 SDA low. P3 SCL low. This also serves as a repeated START.
  - DATA, 8 bits MSB first via a 3-bit counter: P0 SCL low, set SDA (WR: data bit; RD: release). P1 release SCL, stretch wait. P2 sample sda at phase end. P3 SCL low.
  - ACK: same bit timing. WR releases SDA and samples; a 1 sets NACKED. RD drives ACK (0), or releases SDA if NACK is set.
  - STOP: P0 SCL low, SDA low. P1 release SCL, stretch wait. P2 release SDA. P3 idle.
  - FINISH: set DONE, clear BUSY, return to IDLE.
- Clock stretching: the P1 counter does not advance until synchronized SCL reads 1. There is no timeout.
- After WR/RD without STOP, SCL is left driven low and SDA released. The bus stays owned.
- No arbitration or multi-master support.

## Timing
- Reset values: scl_oe=0, sda_oe=0, irq=0, csr_do=0, all registers 0, FSM IDLE.
- Asserting rst_n mid-transfer releases both lines immediately. Software must recover the bus.
- CMD write in cycle N makes BUSY read 1 from cycle N+1. The first SCL/SDA change occurs by cycle N+2.
- Durations, without stretching:
  - START: 4·CLK_DIV (+2 sync).
  - Byte plus ACK: 36·CLK_DIV.
  - STOP: 4·CLK_DIV.
  - FINISH: 1 cycle.
- csr_do is combinational from registers and csr_a.
- irq is registered: it rises 1 cycle after DONE sets.

## Test plan
- Reset: rst_n=0 with lines active → scl_oe=sda_oe=0, irq=0, STATUS=0x00 immediately.
- Write DATA=0xA0, CMD=0x15 (START|WR|IRQ_EN), model ACKs → START seen, SDA bits 1010_0000, STATUS=0x30, irq=1, SCL held low. CMD=0x30 → irq=0.
- CMD=0x4A (RD|STOP|NACK), model sends 0x5A → DATA=0x5A, SDA released in ACK bit, STOP seen, BUSY=0, SCL/SDA released.
- No target, CMD=0x07 with DATA=0x90 → NACKED=1, STOP generated, STATUS=0x60.
- Model holds SCL low 100 cycles in bit 3 of a write → that high phase starts after release, byte still correct, total extended by ≥100 cycles.
- While BUSY, write DATA=0xFF and CMD=0x03 → both ignored, transfer unchanged. rst_n pulse mid-byte → lines released, STATUS=0x00.

Source files
------------

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - CSR-controlled I2C bus initiator with byte commands and clock stretching
module i2c_master #(
    parameter logic [4:0] BASE_ADDR = 5'h1c,
    parameter logic [7:0] CLK_DIV   = 8'd12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       irq
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_FINISH} state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s;
    logic [7:0] cnt;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic       busy, nacked, done, irq_en, nack_cfg;
    logic       do_stop, do_wr, do_rd;
    logic [7:0] tx_byte, rx_byte, shreg;
    logic       cmd_hit, data_hit, phase_end, in_bit;

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign cmd_hit  = csr_we && (csr_a == BASE_ADDR) && !busy;
    assign data_hit = csr_we && (csr_a == BASE_ADDR + 5'd1) && !busy;
    assign in_bit   = (state == S_START) || (state == S_DATA) || (state == S_ACK) || (state == S_STOP);
    // Phase P1 only finishes once the released SCL is actually seen high.
    assign phase_end = (cnt == CLK_DIV - 8'd1) && (phase != 2'd1 || scl_s);

    always_comb begin
        csr_do = 8'h00;
        if (csr_a == BASE_ADDR)
            csr_do = {busy, nacked, done, irq_en, 4'b0000};
        else if (csr_a == BASE_ADDR + 5'd1)
            csr_do = rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b00;
            sda_sync <= 2'b00;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            busy     <= 1'b0;
            nacked   <= 1'b0;
            done     <= 1'b0;
            irq_en   <= 1'b0;
            nack_cfg <= 1'b0;
            do_stop  <= 1'b0;
            do_wr    <= 1'b0;
            do_rd    <= 1'b0;
            tx_byte  <= 8'd0;
            rx_byte  <= 8'd0;
            shreg    <= 8'd0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= done & irq_en;
            if (data_hit)
                tx_byte <= csr_di;
            if (cmd_hit) begin
                irq_en   <= csr_di[4];
                nack_cfg <= csr_di[6];
                if (csr_di[5])
                    done <= 1'b0;
                if (csr_di[3:0] != 4'd0) begin
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    nacked  <= 1'b0;
                    do_stop <= csr_di[1];
                    do_wr   <= csr_di[2];
                    do_rd   <= csr_di[3] & ~csr_di[2];
                    shreg   <= tx_byte;
                    cnt     <= 8'd0;
                    phase   <= 2'd0;
                    bit_cnt <= 3'd0;
                    if (csr_di[0])
                        state <= S_START;
                    else if (csr_di[3:2] != 2'b00)
                        state <= S_DATA;
                    else
                        state <= S_STOP;
                end
            end
            if (in_bit) begin
                if (phase_end) begin
                    cnt   <= 8'd0;
                    phase <= phase + 2'd1;
                end else if (phase != 2'd1 || scl_s) begin
                    cnt <= cnt + 8'd1;
                end
            end
            case (state)
                S_START: begin
                    case (phase)
                        2'd0: sda_oe <= 1'b0;
                        2'd1: scl_oe <= 1'b0;
                        2'd2: sda_oe <= 1'b1;
                        default: scl_oe <= 1'b1;
                    endcase
                    if (phase_end && phase == 2'd3)
                        state <= (do_wr | do_rd) ? S_DATA : (do_stop ? S_STOP : S_FINISH);
                end
                S_DATA: begin
                    case (phase)
                        2'd0: begin
                            scl_oe <= 1'b1;
                            sda_oe <= do_wr & ~shreg[7];
                        end
                        2'd1: scl_oe <= 1'b0;
                        2'd3: scl_oe <= 1'b1;
                        default: ;
                    endcase
                    // Writes shift out and reads shift in through the same register.
                    if (phase_end && phase == 2'd2)
                        shreg <= {shreg[6:0], sda_s};
                    if (phase_end && phase == 2'd3) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_ACK;
                            if (do_rd)
                                rx_byte <= shreg;
                        end
                    end
                end
                S_ACK: begin
                    case (phase)
                        2'd0: begin
                            scl_oe <= 1'b1;
                            sda_oe <= do_rd & ~nack_cfg;
                        end
                        2'd1: scl_oe <= 1'b0;
                        2'd3: scl_oe <= 1'b1;
                        default: ;
                    endcase
                    if (phase_end && phase == 2'd2 && do_wr && sda_s)
                        nacked <= 1'b1;
                    if (phase_end && phase == 2'd3)
                        state <= do_stop ? S_STOP : S_FINISH;
                end
                S_STOP: begin
                    case (phase)
                        2'd0: begin
                            scl_oe <= 1'b1;
                            sda_oe <= 1'b1;
                        end
                        2'd1: scl_oe <= 1'b0;
                        2'd2: sda_oe <= 1'b0;
                        default: ;
                    endcase
                    if (phase_end && phase == 2'd3)
                        state <= S_FINISH;
                end
                S_FINISH: begin
                    sda_oe <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - bench for i2c_master with an I2C target model and bus monitor
`timescale 1ns/1ps
module tb_i2c_master;
    localparam logic [4:0] BASE   = 5'h1c;
    localparam logic [4:0] DATA_A = 5'h1d;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] csr_a = 5'd0;
    logic [7:0] csr_di = 8'd0;
    logic       csr_we = 1'b0;
    wire  [7:0] csr_do;
    wire        scl_oe, sda_oe, irq;
    logic       scl_hold = 1'b0;
    logic       sda_drv = 1'b0;
    wire        scl = ~scl_oe & ~scl_hold;
    wire        sda = ~sda_oe & ~sda_drv;

    int vectors = 0;
    int miscompares = 0;

    i2c_master #(.BASE_ADDR(5'h1c), .CLK_DIV(8'd12)) dut (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .scl_in(scl), .sda_in(sda), .scl_oe(scl_oe), .sda_oe(sda_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    logic       bits[$];
    int         starts = 0, stops = 0, idx = 0, byte_base = 0;
    bit         start_flag = 0, active = 0;
    int         tgt_mode = 0;
    logic [7:0] tgt_byte = 8'd0;
    bit         tgt_ack = 0;
    int         stretch_slot = -1;

    // Target behaviour per SCL-low slot: 0..7 data bits, 8 acknowledge.
    function automatic logic slave_val(int slot);
        if (!active) return 1'b0;
        if (tgt_mode == 1) return (slot == 8) && tgt_ack;
        if (tgt_mode == 2 && slot >= 0 && slot < 8) return ~tgt_byte[7 - slot];
        return 1'b0;
    endfunction

    always @(negedge sda) if (scl === 1'b1 && rst_n) begin starts++; start_flag = 1; end
    always @(posedge sda) if (scl === 1'b1) begin stops++; active = 0; sda_drv = 1'b0; end

    always @(negedge scl) begin
        if (start_flag) begin
            start_flag = 0; active = 1; idx = 0; byte_base = 0;
        end else begin
            bits.push_back(sda);
            idx++;
        end
        #20;
        sda_drv = slave_val(idx - byte_base);
        if (active && (idx - byte_base) == stretch_slot) begin
            scl_hold = 1'b1;
            for (int k = 0; k < 1000 && scl_oe !== 1'b0; k++) @(negedge clk);
            repeat (100) @(negedge clk);
            scl_hold = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        @(posedge clk); #1;
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [4:0] a, output logic [7:0] d);
        csr_a = a; #1;
        d = csr_do;
    endtask

    task automatic arm(input int mode, input logic [7:0] b, input bit ack, input bit has_start);
        tgt_mode = mode; tgt_byte = b; tgt_ack = ack; byte_base = idx;
        sda_drv = has_start ? 1'b0 : slave_val(0);
    endtask

    task automatic mon_clear();
        bits.delete(); starts = 0; stops = 0; start_flag = 0;
    endtask

    task automatic slave_reset();
        active = 0; sda_drv = 1'b0; scl_hold = 1'b0; tgt_mode = 0; mon_clear();
    endtask

    function automatic logic [31:0] bits_val();
        logic [31:0] v = 32'd0;
        foreach (bits[i]) v = {v[30:0], bits[i]};
        return v;
    endfunction

    // Reference: status and bus bits follow directly from command, data and target behaviour.
    function automatic logic [7:0] exp_status(logic [7:0] cmd, bit ack);
        bit nk = cmd[2] && !ack;
        return {1'b0, nk, 1'b1, cmd[4], 4'b0000};
    endfunction

    function automatic logic [8:0] exp_bits(logic [7:0] cmd, logic [7:0] txd, logic [7:0] tgt, bit ack);
        if (cmd[2]) return {txd, ~ack};
        return {tgt, cmd[6]};
    endfunction

    task automatic launch(input string tag, input logic [7:0] cmd);
        logic [7:0] st;
        csr_wr(BASE, cmd);
        csr_rd(BASE, st);
        check({tag, " busy"}, {31'd0, st[7]}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input bit ien, output int cycles);
        logic [7:0] st;
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < 20000) begin
            @(posedge clk); #1;
            cycles++;
            csr_rd(BASE, st);
            if (st[5] && !st[7]) seen = 1;
        end
        check({tag, " done"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, " irq_lag"}, {31'd0, irq}, 32'd0);
            @(posedge clk); #1;
            check({tag, " irq"}, {31'd0, irq}, {31'd0, ien});
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] cmd, input logic [7:0] txd, input int mode,
                        input logic [7:0] tgt, input bit ack, input bit meddle, output int cycles);
        logic [7:0] st, rx_prev, rd;
        logic [8:0] eb;
        csr_rd(DATA_A, rx_prev);
        csr_wr(DATA_A, txd);
        arm(mode, tgt, ack, cmd[0]);
        mon_clear();
        launch(tag, cmd);
        if (meddle) begin
            repeat (300) @(posedge clk);
            csr_wr(DATA_A, 8'hFF);
            csr_wr(BASE, 8'h03);
        end
        wait_done(tag, cmd[4], cycles);
        eb = exp_bits(cmd, txd, tgt, ack);
        check({tag, " nbits"}, bits.size(), 32'd9);
        check({tag, " byte"}, bits_val(), {23'd0, eb});
        check({tag, " starts"}, starts, {31'd0, cmd[0]});
        check({tag, " stops"}, stops, {31'd0, cmd[1]});
        csr_rd(BASE, st);
        check({tag, " status"}, {24'd0, st}, {24'd0, exp_status(cmd, ack)});
        csr_rd(DATA_A, rd);
        check({tag, " data"}, {24'd0, rd}, {24'd0, (cmd[3] && !cmd[2]) ? tgt : rx_prev});
        check({tag, " scl_oe"}, {31'd0, scl_oe}, {31'd0, ~cmd[1]});
        check({tag, " sda_oe"}, {31'd0, sda_oe}, 32'd0);
    endtask

    initial begin
        logic [7:0] st, cmd, txd, tgt;
        int c0, c1;
        bit ack;

        #2 rst_n = 1'b0;
        #1;
        csr_rd(BASE, st);
        check("rst status", {24'd0, st}, 32'd0);
        check("rst scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slave_reset();
        repeat (4) @(posedge clk);

        xfer("wr_a0", 8'h15, 8'hA0, 1, 8'h00, 1'b1, 1'b0, c0);
        csr_wr(BASE, 8'h30);
        @(posedge clk); #1;
        check("irq_clear", {31'd0, irq}, 32'd0);
        csr_rd(BASE, st);
        check("status_after_clear", {24'd0, st}, 32'h10);

        xfer("rd_5a", 8'h4A, 8'h00, 2, 8'h5A, 1'b0, 1'b0, c0);
        xfer("no_target", 8'h07, 8'h90, 0, 8'h00, 1'b0, 1'b0, c0);

        txd = 8'($urandom);
        xfer("base", 8'h07, txd, 1, 8'h00, 1'b1, 1'b0, c0);
        stretch_slot = 3;
        xfer("stretch", 8'h07, txd, 1, 8'h00, 1'b1, 1'b0, c1);
        stretch_slot = -1;
        check("stretch_ext", {31'd0, (c1 >= c0 + 100)}, 32'd1);

        xfer("busy_ign", 8'h15, 8'h3C, 1, 8'h00, 1'b1, 1'b1, c0);

        csr_wr(DATA_A, 8'hC3);
        arm(1, 8'h00, 1'b1, 1'b1);
        launch("rst_mid", 8'h07);
        repeat (200) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst_mid sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_mid irq", {31'd0, irq}, 32'd0);
        csr_rd(BASE, st);
        check("rst_mid status", {24'd0, st}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slave_reset();
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            cmd = ($urandom_range(0, 1) != 0) ? 8'h07 : 8'h0B;
            if ($urandom_range(0, 1) != 0) cmd = cmd | 8'h10;
            if ($urandom_range(0, 1) != 0) cmd = cmd | 8'h40;
            txd = 8'($urandom);
            tgt = 8'($urandom);
            ack = ($urandom_range(0, 1) != 0);
            xfer("rand", cmd, txd, cmd[2] ? 1 : 2, tgt, ack, 1'b0, c0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
